// File: rtl/cla_stream_accumulator.sv
// Block accumulator for 16-bit unsigned operands built around a two-level 16-bit
// carry-lookahead adder; carry-outs are counted to form the upper result byte.

module cla_group4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       grp_g,
    output logic       grp_p
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every in-group carry is a flat sum of products of g/p and the group carry-in.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

    assign sum   = p ^ c;
    assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign grp_p = &p;
endmodule

module cla_adder16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [3:0] gg;
    logic [3:0] gp;
    logic [3:0] gc;

    for (genvar k = 0; k < 4; k++) begin : g_grp
        cla_group4 u_grp (
            .a     (a[4*k +: 4]),
            .b     (b[4*k +: 4]),
            .cin   (gc[k]),
            .sum   (sum[4*k +: 4]),
            .grp_g (gg[k]),
            .grp_p (gp[k])
        );
    end

    // Second lookahead level: group carries come straight from group G/P terms.
    assign gc[0] = cin;
    assign gc[1] = gg[0] | (gp[0] & cin);
    assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & cin);
    assign cout  = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0])
                 | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
endmodule

module cla_stream_accumulator #(
    parameter int COUNT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_sum,
    output logic [7:0]  out_count
);
    if (COUNT < 1 || COUNT > 255) begin : g_bad_count
        $error("cla_stream_accumulator: COUNT must be in 1..255");
    end

    localparam logic [7:0] COUNT_W = 8'(COUNT);

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] acc;
    logic [15:0] acc_next;
    logic [7:0]  carry_cnt;
    logic [7:0]  carry_cnt_next;
    logic [7:0]  cnt;
    logic [7:0]  cnt_next;
    logic [15:0] add_sum;
    logic        add_cout;
    logic        closing;

    cla_adder16 u_adder (
        .a    (acc),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign closing = ((cnt + 8'd1) == COUNT_W) || in_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ACCUM;
            acc       <= 16'd0;
            carry_cnt <= 8'd0;
            cnt       <= 8'd0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            carry_cnt <= carry_cnt_next;
            cnt       <= cnt_next;
        end
    end

    // clear outranks both the input beat and the output handshake.
    always_comb begin
        state_next     = state;
        acc_next       = acc;
        carry_cnt_next = carry_cnt;
        cnt_next       = cnt;
        unique case (state)
            ACCUM: begin
                if (clear) begin
                    acc_next       = 16'd0;
                    carry_cnt_next = 8'd0;
                    cnt_next       = 8'd0;
                end else if (in_valid) begin
                    acc_next       = add_sum;
                    carry_cnt_next = carry_cnt + {7'd0, add_cout};
                    cnt_next       = cnt + 8'd1;
                    if (closing) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (clear || out_ready) begin
                    state_next     = ACCUM;
                    acc_next       = 16'd0;
                    carry_cnt_next = 8'd0;
                    cnt_next       = 8'd0;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign out_sum   = {carry_cnt, acc};
    assign out_count = cnt;
endmodule

// File: tb/tb_cla_stream_accumulator.sv
// Bench for cla_stream_accumulator: three instances (COUNT = 2, 4, 8), a vector
// table, hand-written corner sequences and a randomized run against a sum model.

module tb_cla_stream_accumulator;
    localparam int S2 = 0;
    localparam int S4 = 1;
    localparam int S8 = 2;

    logic        clk;
    logic        rst_n;
    logic [2:0]  clear;
    logic [2:0]  in_valid;
    logic [2:0]  in_last;
    logic [2:0]  out_ready;
    logic [15:0] in_data [3];
    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [23:0] out_sum [3];
    logic [7:0]  out_count [3];

    int checks;
    int errors;

    cla_stream_accumulator #(.COUNT(2)) u_c2 (
        .clk(clk), .rst_n(rst_n), .clear(clear[S2]), .in_valid(in_valid[S2]),
        .in_ready(in_ready[S2]), .in_data(in_data[S2]), .in_last(in_last[S2]),
        .out_valid(out_valid[S2]), .out_ready(out_ready[S2]),
        .out_sum(out_sum[S2]), .out_count(out_count[S2])
    );

    cla_stream_accumulator #(.COUNT(4)) u_c4 (
        .clk(clk), .rst_n(rst_n), .clear(clear[S4]), .in_valid(in_valid[S4]),
        .in_ready(in_ready[S4]), .in_data(in_data[S4]), .in_last(in_last[S4]),
        .out_valid(out_valid[S4]), .out_ready(out_ready[S4]),
        .out_sum(out_sum[S4]), .out_count(out_count[S4])
    );

    cla_stream_accumulator #(.COUNT(8)) u_c8 (
        .clk(clk), .rst_n(rst_n), .clear(clear[S8]), .in_valid(in_valid[S8]),
        .in_ready(in_ready[S8]), .in_data(in_data[S8]), .in_last(in_last[S8]),
        .out_valid(out_valid[S8]), .out_ready(out_ready[S8]),
        .out_sum(out_sum[S8]), .out_count(out_count[S8])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              sel;
        int              n;
        logic [3:0][15:0] d;
        logic            last;
        logic [23:0]     exp_sum;
        logic [7:0]      exp_cnt;
    } vec_t;

    vec_t vecs [7];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic v, input logic [15:0] d,
                                 input logic l);
        in_valid[sel] = v;
        in_data[sel]  = d;
        in_last[sel]  = l;
        @(posedge clk);
        #1;
        in_valid[sel] = 1'b0;
        in_last[sel]  = 1'b0;
    endtask

    task automatic checkResult(input int sel, input string name, input logic [23:0] s,
                               input logic [7:0] c);
        checkOutput({name, ".out_valid"}, 32'(out_valid[sel]), 32'd1);
        checkOutput({name, ".in_ready"},  32'(in_ready[sel]),  32'd0);
        checkOutput({name, ".out_sum"},   32'(out_sum[sel]),   32'(s));
        checkOutput({name, ".out_count"}, 32'(out_count[sel]), 32'(c));
    endtask

    task automatic checkReset(input int sel, input string name);
        checkOutput({name, ".out_valid"}, 32'(out_valid[sel]), 32'd0);
        checkOutput({name, ".out_sum"},   32'(out_sum[sel]),   32'd0);
        checkOutput({name, ".out_count"}, 32'(out_count[sel]), 32'd0);
        checkOutput({name, ".in_ready"},  32'(in_ready[sel]),  32'd1);
    endtask

    task automatic runBlock(input int sel, input int n, input logic [15:0] val);
        for (int i = 0; i < n; i++) applyStimulus(sel, 1'b1, val, 1'b0);
    endtask

    int          m_sum;
    int          m_n;
    bit          m_done;
    int          m_results;
    logic        rv;
    logic        rl;
    logic        rr;
    logic        rc;
    logic [15:0] rd;

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        clear     = '0;
        in_valid  = '0;
        in_last   = '0;
        out_ready = '1;
        for (int i = 0; i < 3; i++) in_data[i] = 16'd0;

        vecs[0] = '{S4, 4, {16'd4, 16'd3, 16'd2, 16'd1}, 1'b0, 24'h00000A, 8'd4};
        vecs[1] = '{S4, 4, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 1'b0, 24'h03FFFC, 8'd4};
        vecs[2] = '{S4, 4, {16'h0000, 16'h0000, 16'hFFFF, 16'h0001}, 1'b0, 24'h010000, 8'd4};
        vecs[3] = '{S8, 2, {16'h0000, 16'h0000, 16'h8000, 16'h8000}, 1'b1, 24'h010000, 8'd2};
        vecs[4] = '{S2, 2, {16'h0000, 16'h0000, 16'h1111, 16'h1234}, 1'b0, 24'h002345, 8'd2};
        vecs[5] = '{S8, 1, {16'h0000, 16'h0000, 16'h0000, 16'h0005}, 1'b1, 24'h000005, 8'd1};
        vecs[6] = '{S4, 4, {16'd2, 16'd2, 16'd2, 16'd2}, 1'b0, 24'h000008, 8'd4};

        @(posedge clk);
        #1;
        checkReset(S4, "reset_init");
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < vecs[v].n; i++) begin
                applyStimulus(vecs[v].sel, 1'b1, vecs[v].d[i],
                              vecs[v].last && (i == vecs[v].n - 1));
            end
            checkResult(vecs[v].sel, $sformatf("vec%0d", v), vecs[v].exp_sum, vecs[v].exp_cnt);
            applyStimulus(vecs[v].sel, 1'b0, 16'd0, 1'b0);
            checkOutput($sformatf("vec%0d.one_cycle", v), 32'(out_valid[vecs[v].sel]), 32'd0);
            checkOutput($sformatf("vec%0d.ready_back", v), 32'(in_ready[vecs[v].sel]), 32'd1);
        end

        // Early close separated by idle cycles, one with in_last but no in_valid.
        applyStimulus(S8, 1'b1, 16'h8000, 1'b0);
        applyStimulus(S8, 1'b0, 16'h1234, 1'b1);
        checkOutput("bubble.idle1", 32'(out_valid[S8]), 32'd0);
        applyStimulus(S8, 1'b0, 16'h0000, 1'b0);
        checkOutput("bubble.idle2", 32'(out_valid[S8]), 32'd0);
        applyStimulus(S8, 1'b1, 16'h8000, 1'b1);
        checkResult(S8, "bubble", 24'h010000, 8'd2);
        applyStimulus(S8, 1'b0, 16'd0, 1'b0);
        applyStimulus(S8, 1'b1, 16'd5, 1'b1);
        checkResult(S8, "bubble_next", 24'h000005, 8'd1);
        applyStimulus(S8, 1'b0, 16'd0, 1'b0);

        // Backpressure: result holds and stalled operands are refused.
        out_ready[S2] = 1'b0;
        applyStimulus(S2, 1'b1, 16'h1234, 1'b0);
        applyStimulus(S2, 1'b1, 16'h1111, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkResult(S2, $sformatf("stall%0d", i), 24'h002345, 8'd2);
            applyStimulus(S2, 1'b1, 16'h9999, 1'b0);
        end
        out_ready[S2] = 1'b1;
        applyStimulus(S2, 1'b0, 16'd0, 1'b0);
        checkOutput("stall.release", 32'(out_valid[S2]), 32'd0);
        applyStimulus(S2, 1'b1, 16'd1, 1'b0);
        applyStimulus(S2, 1'b1, 16'd1, 1'b0);
        checkResult(S2, "stall_next", 24'h000002, 8'd2);
        applyStimulus(S2, 1'b0, 16'd0, 1'b0);

        // Clear in ACCUM with a simultaneous operand, then clear in DONE.
        applyStimulus(S4, 1'b1, 16'd7, 1'b0);
        applyStimulus(S4, 1'b1, 16'd7, 1'b0);
        clear[S4] = 1'b1;
        applyStimulus(S4, 1'b1, 16'd9, 1'b0);
        clear[S4] = 1'b0;
        runBlock(S4, 4, 16'd1);
        checkResult(S4, "clear_accum", 24'h000004, 8'd4);
        applyStimulus(S4, 1'b0, 16'd0, 1'b0);
        out_ready[S4] = 1'b0;
        runBlock(S4, 4, 16'd3);
        checkResult(S4, "clear_done_pre", 24'h00000C, 8'd4);
        clear[S4] = 1'b1;
        applyStimulus(S4, 1'b0, 16'd0, 1'b0);
        clear[S4] = 1'b0;
        checkOutput("clear_done.out_valid", 32'(out_valid[S4]), 32'd0);
        checkOutput("clear_done.in_ready", 32'(in_ready[S4]), 32'd1);
        out_ready[S4] = 1'b1;
        runBlock(S4, 4, 16'd5);
        checkResult(S4, "clear_done_next", 24'h000014, 8'd4);
        applyStimulus(S4, 1'b0, 16'd0, 1'b0);

        // Reset mid-block (held two cycles with operands offered), then in DONE.
        runBlock(S4, 3, 16'hFFFF);
        rst_n = 1'b0;
        applyStimulus(S4, 1'b1, 16'hFFFF, 1'b1);
        applyStimulus(S4, 1'b1, 16'hFFFF, 1'b1);
        rst_n = 1'b1;
        checkReset(S4, "reset_mid");
        out_ready[S4] = 1'b0;
        runBlock(S4, 4, 16'hFFFF);
        checkResult(S4, "reset_done_pre", 24'h03FFFC, 8'd4);
        rst_n = 1'b0;
        applyStimulus(S4, 1'b0, 16'd0, 1'b0);
        rst_n = 1'b1;
        checkReset(S4, "reset_done");
        out_ready[S4] = 1'b1;
        runBlock(S4, 4, 16'd2);
        checkResult(S4, "reset_fresh", 24'h000008, 8'd4);
        applyStimulus(S4, 1'b0, 16'd0, 1'b0);

        // Randomized traffic on the COUNT=8 instance against a running-sum model.
        m_sum     = 0;
        m_n       = 0;
        m_done    = 0;
        m_results = 0;
        rst_n     = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rv = ($urandom_range(0, 3) != 0);
            rl = ($urandom_range(0, 7) == 0);
            rr = ($urandom_range(0, 2) != 0);
            rc = ($urandom_range(0, 49) == 0);
            rd = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            clear[S8]     = rc;
            out_ready[S8] = rr;
            if (rc) begin
                m_sum  = 0;
                m_n    = 0;
                m_done = 0;
            end else if (!m_done) begin
                if (rv) begin
                    m_sum += int'(rd);
                    m_n++;
                    if (m_n == 8 || rl) m_done = 1;
                end
            end else if (rr) begin
                m_sum  = 0;
                m_n    = 0;
                m_done = 0;
                m_results++;
            end
            applyStimulus(S8, rv, rd, rl);
            checkOutput("rand.out_valid", 32'(out_valid[S8]), 32'(m_done));
            checkOutput("rand.in_ready", 32'(in_ready[S8]), 32'(!m_done));
            if (m_done) begin
                checkOutput("rand.out_sum", 32'(out_sum[S8]), 32'(m_sum[23:0]));
                checkOutput("rand.out_count", 32'(out_count[S8]), 32'(m_n));
            end
        end
        clear[S8] = 1'b0;
        $display("[TB] random phase saw %0d accepted results", m_results);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cla_stream_accumulator.md
# cla_stream_accumulator

- Accumulates a stream of 16-bit unsigned operands into a 24-bit block sum and emits one result per block.
- Block length is the parameter `COUNT`, or shorter when an operand arrives with `in_last`.
- All additions go through one instance of the team's 16-bit carry-lookahead adder with `cin` = 0. Its `cout` feeds an 8-bit carry counter that forms the upper result bits.
- Sits directly downstream of the adder and consumes its sum and carry-out.

## Interface

Parameters:
- `COUNT`, default 8: operands per block. Legal range 1..255; values outside this range are illegal.

Ports:
- `clk`  input  1: single clock; all logic is on the rising edge.
- `rst_n`  input  1: synchronous, active-low reset.
- `clear`  input  1: synchronous abort of the current block.
- `in_valid`  input  1: operand valid.
- `in_ready`  output  1: block can accept an operand.
- `in_data`  input  16: unsigned operand.
- `in_last`  input  1: the operand on this beat closes the block early.
- `out_valid`  output  1: result valid.
- `out_ready`  input  1: downstream accepts the result.
- `out_sum`  output  24: block sum, formed as {carry_cnt[7:0], acc[15:0]}.
- `out_count`  output  8: number of operands in the block, 1..COUNT.

## Operation

States:
- **ACCUM** (reset state). `in_ready`=1 and `out_valid`=0.
- **DONE**. `in_ready`=0 and `out_valid`=1.

Input beat:
- A beat happens when `in_valid` && `in_ready` are both high at a rising edge.

On each beat in ACCUM:
- `acc` <= adder sum of `acc` + `in_data`, with `cin`=0.
- `carry_cnt` <= `carry_cnt` + adder `cout`.
- `cnt` <= `cnt` + 1.

Block close:
- The block closes on a beat where `cnt`+1 == `COUNT`, or where `in_last`=1.
- On that beat the state moves to DONE.
- `out_sum`/`out_count` then present the updated `acc`/`carry_cnt`/`cnt` values.

DONE:
- Outputs hold stable while `out_ready`=0.
- On `out_valid` && `out_ready`: `acc`, `carry_cnt` and `cnt` clear to 0, and the state returns to ACCUM.

Width rules:
- `carry_cnt` cannot overflow: at most COUNT−1 ≤ 254 carries, since COUNT·(2^16−1) < 2^24.
- `out_count` never reads 0 while `out_valid`=1.

Priority: `rst_n` low > `clear` > beat/handshake.
- `clear`=1 in ACCUM: `acc`, `carry_cnt` and `cnt` go to 0. An operand presented in the same cycle is discarded.
- `clear`=1 in DONE: the pending result is dropped, the state returns to ACCUM, and counters clear. No output handshake is counted.

Other rules:
- `in_data` and `in_last` are ignored when no beat occurs.
- `in_last`=1 with `in_valid`=0 has no effect.

## Timing

Reset:
- Any rising edge with `rst_n`=0 sets state=ACCUM and `acc`=`carry_cnt`=`cnt`=0.
- Outputs after that edge: `out_valid`=0, `out_sum`=0, `out_count`=0, `in_ready`=1.
- While `rst_n`=0, inputs have no effect.
- Reset mid-block or in DONE discards everything.

Outputs:
- `in_ready` and `out_valid` are decoded from the state register only. There is no combinational path from `in_valid` or `out_ready`.
- `out_sum` and `out_count` are registered. In ACCUM they show running values, which are don't-care for checking.

Latency and throughput:
- Latency: closing beat at edge t → `out_valid`=1 from t (visible in the cycle after edge t).
- Peak rate: one operand per cycle within a block.
- Minimum block period is COUNT+1 cycles, because no operand is accepted in the DONE cycle.
- The earliest next beat is at the same edge as the output handshake plus one cycle.

Gaps:
- `in_valid` gaps stall accumulation and do not change state.

The adder path (16-bit CLA plus the 8-bit carry increment) must close timing in one cycle.

## Test plan

- **Sum without carries.** COUNT=4; beats 1, 2, 3, 4 back-to-back with `out_ready`=1.
  - Required: `out_valid` for exactly one cycle, after the 4th beat.
  - Required: `out_sum`=0x00000A, `out_count`=4; `in_ready`=0 in that cycle.
- **Carry chain.** COUNT=4; 0xFFFF ×4.
  - Required: `out_sum`=0x03FFFC, `out_count`=4.
  - Then 0x0001, 0xFFFF, 0x0000, 0x0000 → `out_sum`=0x010000. This exercises the full-carry ripple through every 4-bit group.
- **Early close with bubbles.** COUNT=8; 0x8000, idle 2 cycles, then 0x8000 with `in_last`=1.
  - Required: `out_sum`=0x010000, `out_count`=2.
  - Next block: 5 → `out_sum`=0x000005 (accumulator was cleared).
- **Backpressure.** COUNT=2; 0x1234, 0x1111 with `out_ready`=0 for 5 cycles.
  - Required: `out_valid`=1, `out_sum`=0x002345 stable, `in_ready`=0 throughout.
  - Required: `in_valid`=1 on 0x9999 during the stall is not accepted.
  - After `out_ready` rises, the next block begins at 0.
- **Clear.** COUNT=4; beats 7, 7, then `clear`=1 together with `in_valid`=1 on 9, then 1, 1, 1, 1.
  - Required: `out_sum`=0x000004.
  - `clear` in DONE: `out_valid` drops the next cycle and no result is seen.
- **Reset.** Pull `rst_n` low for one cycle mid-block (after 3 beats of 0xFFFF) and again while in DONE.
  - Required after each: `out_valid`=0, `out_sum`=0, `out_count`=0, `in_ready`=1.
  - Required: a fresh COUNT=4 block of 2s returns 0x000008.
